jpeg_block_symbol_sequencer: RTL and testbench

Walks one 8x8 block of quantized coefficients in zigzag order and drives the combinational coefficient_encoder, one coefficient at a time. It forms the DC difference against a running predictor, counts AC zero runs, and inserts ZRL and EOB markers. It emits (run, size, value) symbols over a valid/ready stream to the downstream Huffman packer. It sits between the quantized-block buffer and the Huffman stage.

---
 rtl/jpeg_entropy_pkg.sv | 27 ++
 rtl/coefficient_encoder.sv | 41 ++++
 rtl/jpeg_block_symbol_sequencer.sv | 163 ++++++++++++++++
 tb/tb_jpeg_block_symbol_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/jpeg_entropy_pkg.sv
// Shared types and constants for the JPEG entropy front end.
//   sym_hdr_t   : symbol header (is_dc, run, size); the value travels alongside
//                 at the coefficient width of the instantiating block.
//   seq_state_e : block symbol sequencer FSM states.
package jpeg_entropy_pkg;

  localparam logic [3:0] ZRL_RUN          = 4'd15;
  localparam logic [3:0] EOB_RUN          = 4'd0;
  localparam logic [5:0] BLOCK_LAST_INDEX = 6'd63;

  typedef struct packed {
    logic       is_dc;
    logic [3:0] run;
    logic [3:0] size;
  } sym_hdr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_EMIT,
    S_ZRL,
    S_EOB,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/coefficient_encoder.sv
// Combinational JPEG magnitude-category encoder.
//   coef : signed input value
//   size : magnitude category (bit length of |coef|, saturated at 15)
//   code : low 'size' bits hold coef (positive) or ones-complement of |coef|
//          (negative); all upper bits are zero.
module coefficient_encoder #(
  parameter int COEF_WIDTH = 16
) (
  input  logic signed [COEF_WIDTH-1:0] coef,
  output logic        [3:0]            size,
  output logic        [COEF_WIDTH-1:0] code
);

  localparam logic [COEF_WIDTH-1:0] ONE = 1;

  logic [COEF_WIDTH-1:0] mag;
  logic [COEF_WIDTH-1:0] adj;
  logic [COEF_WIDTH-1:0] mask;
  logic [4:0]            bits;

  always_comb begin
    mag = coef;
    if (coef[COEF_WIDTH-1]) mag = ~coef + ONE;

    bits = '0;
    for (int i = 0; i < COEF_WIDTH; i++)
      if (mag[i]) bits = 5'(i + 1);
    size = (bits > 5'd15) ? 4'd15 : bits[3:0];

    mask = '0;
    for (int i = 0; i < COEF_WIDTH; i++)
      mask[i] = (i < int'(size));

    // Two's complement minus one equals the ones-complement of the magnitude
    // in the low 'size' bits.
    adj = coef;
    if (coef[COEF_WIDTH-1]) adj = adj - ONE;
    code = adj & mask;
  end

endmodule

// File: rtl/jpeg_block_symbol_sequencer.sv
// Walks one 8x8 block in zigzag order and emits (run, size, value) symbols.
//   clock, reset_n        : clock, async active-low reset
//   start, clear_pred     : block start (IDLE only); zero DC predictor first
//   busy, done            : block in progress; one-cycle completion pulse
//   coef_rd_en, coef_addr : block buffer read; data returns one cycle later
//   coef_data             : signed quantized coefficient
//   sym_valid/sym_ready   : symbol stream handshake
//   sym_is_dc, sym_run, sym_size, sym_value : symbol fields (0 when idle)
module jpeg_block_symbol_sequencer
  import jpeg_entropy_pkg::*;
#(
  parameter int COEF_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         clear_pred,
  output logic                         busy,
  output logic                         done,
  output logic                         coef_rd_en,
  output logic        [5:0]            coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic                         sym_valid,
  input  logic                         sym_ready,
  output logic                         sym_is_dc,
  output logic        [3:0]            sym_run,
  output logic        [3:0]            sym_size,
  output logic        [COEF_WIDTH-1:0] sym_value
);

  seq_state_e                  state_q, state_d;
  logic        [5:0]           idx_q, idx_d;
  logic        [5:0]           run_q, run_d;
  logic signed [COEF_WIDTH-1:0] pred_q, pred_d;
  sym_hdr_t                    hdr_q, hdr_d;
  logic        [COEF_WIDTH-1:0] val_q, val_d;

  logic signed [COEF_WIDTH-1:0] diff;
  logic signed [COEF_WIDTH-1:0] enc_in;
  logic        [3:0]            enc_size;
  logic        [COEF_WIDTH-1:0] enc_code;
  logic        [5:0]            run_rem;

  // Wrap-around truncation of the diff is intended for out-of-range inputs.
  assign diff    = coef_data - pred_q;
  assign enc_in  = (idx_q == 6'd0) ? diff : coef_data;
  assign run_rem = run_q - 6'd16;

  coefficient_encoder #(.COEF_WIDTH(COEF_WIDTH)) u_enc (
    .coef (enc_in),
    .size (enc_size),
    .code (enc_code)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      run_q   <= '0;
      pred_q  <= '0;
      hdr_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      pred_q  <= pred_d;
      hdr_q   <= hdr_d;
      val_q   <= val_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    run_d   = run_q;
    pred_d  = pred_q;
    hdr_d   = hdr_q;
    val_d   = val_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_READ;
        idx_d   = '0;
        run_d   = '0;
        if (clear_pred) pred_d = '0;
      end
      S_READ: state_d = S_EVAL;
      S_EVAL: begin
        if (idx_q == 6'd0) begin
          pred_d  = coef_data;
          hdr_d   = '{is_dc: 1'b1, run: 4'd0, size: enc_size};
          val_d   = enc_code;
          state_d = S_EMIT;
        end else if (coef_data == '0) begin
          run_d = run_q + 6'd1;
          if (idx_q == BLOCK_LAST_INDEX) state_d = S_EOB;
          else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_READ;
          end
        end else begin
          // Symbol is captured now; its run field is finalised once any
          // ZRLs have drained the counter below 16.
          hdr_d = '{is_dc: 1'b0, run: run_q[3:0], size: enc_size};
          val_d = enc_code;
          if (run_q >= 6'd16) state_d = S_ZRL;
          else begin
            run_d   = '0;
            state_d = S_EMIT;
          end
        end
      end
      S_ZRL: if (sym_ready) begin
        run_d = run_rem;
        if (run_rem < 6'd16) begin
          hdr_d.run = run_rem[3:0];
          run_d     = '0;
          state_d   = S_EMIT;
        end
      end
      S_EMIT: if (sym_ready) begin
        if (idx_q == BLOCK_LAST_INDEX) state_d = S_DONE;
        else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_READ;
        end
      end
      S_EOB: if (sym_ready) begin
        run_d   = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        run_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    done       = (state_q == S_DONE);
    coef_rd_en = (state_q == S_READ);
    coef_addr  = idx_q;
    sym_valid  = (state_q == S_EMIT) || (state_q == S_ZRL) || (state_q == S_EOB);
    sym_is_dc  = 1'b0;
    sym_run    = 4'd0;
    sym_size   = 4'd0;
    sym_value  = '0;
    case (state_q)
      S_EMIT: begin
        sym_is_dc = hdr_q.is_dc;
        sym_run   = hdr_q.run;
        sym_size  = hdr_q.size;
        sym_value = val_q;
      end
      S_ZRL:   sym_run = ZRL_RUN;
      S_EOB:   sym_run = EOB_RUN;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jpeg_block_symbol_sequencer.sv
module tb_jpeg_block_symbol_sequencer;
  localparam int W = 16;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                start = 1'b0, clear_pred = 1'b0, sym_ready = 1'b0;
  logic                busy, done, coef_rd_en, sym_valid, sym_is_dc;
  logic [5:0]          coef_addr;
  logic signed [W-1:0] coef_data;
  logic [3:0]          sym_run, sym_size;
  logic [W-1:0]        sym_value;

  int          n_tests = 0, n_fail = 0;
  int          coef_mem[64];
  int          model_pred = 0;
  logic [31:0] exp_q[$];

  jpeg_block_symbol_sequencer #(.COEF_WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .clear_pred(clear_pred),
    .busy(busy), .done(done), .coef_rd_en(coef_rd_en), .coef_addr(coef_addr),
    .coef_data(coef_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_is_dc(sym_is_dc), .sym_run(sym_run), .sym_size(sym_size),
    .sym_value(sym_value)
  );

  always #5 clock = ~clock;

  // Block buffer: one-cycle read latency, garbage when not read.
  always @(posedge clock)
    coef_data <= coef_rd_en ? W'(coef_mem[coef_addr]) : W'($urandom);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // JPEG category/code from plain arithmetic.
  function automatic logic [31:0] pack_sym(input bit dc, input int run, input int v);
    int mag, sz, code;
    mag = (v < 0) ? -v : v;
    sz  = 0;
    while (mag > 0) begin sz++; mag = mag / 2; end
    code = (v >= 0) ? v : v + (1 << sz) - 1;
    return {7'd0, dc, 4'(run), 4'(sz), 16'(code)};
  endfunction

  task automatic build_expected(input bit clr);
    int run = 0;
    if (clr) model_pred = 0;
    exp_q.delete();
    exp_q.push_back(pack_sym(1'b1, 0, coef_mem[0] - model_pred));
    model_pred = coef_mem[0];
    for (int k = 1; k < 64; k++) begin
      if (coef_mem[k] == 0) run++;
      else begin
        while (run >= 16) begin exp_q.push_back(pack_sym(1'b0, 15, 0)); run -= 16; end
        exp_q.push_back(pack_sym(1'b0, run, coef_mem[k]));
        run = 0;
      end
    end
    if (run > 0) exp_q.push_back(pack_sym(1'b0, 0, 0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; sym_ready = 1'b0; start = 1'b0; clear_pred = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_pred = 0;
  endtask

  // mode 0: random ready + stray starts; 1: 5-cycle stall per symbol;
  // 2: like 1 but reset at the first ZRL.
  task automatic run_block(input string tag, input bit clr, input int mode);
    int  wait_n = 0, cyc = 0, last_hs = -10, n_exp;
    bit  fin = 1'b0;
    build_expected(clr);
    n_exp = exp_q.size();
    @(negedge clock); start = 1'b1; clear_pred = clr;
    @(negedge clock); start = 1'b0; clear_pred = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_rd_start"}, {coef_rd_en, coef_addr}, {1'b1, 6'd0});
    while (!fin && cyc < 3000) begin
      if (done) begin
        fin = 1'b1; start = 1'b0; clear_pred = 1'b0;
        chk({tag, "_done_lat"}, cyc - last_hs, 1);
        chk({tag, "_busy_done"}, busy, 0);
      end else if (sym_valid) begin
        if (exp_q.size() > 0)
          chk({tag, "_sym"}, {7'd0, sym_is_dc, sym_run, sym_size, sym_value}, exp_q[0]);
        else
          chk({tag, "_extra_sym"}, {7'd0, sym_is_dc, sym_run, sym_size, sym_value}, 32'hffff_ffff);
        if (mode == 2 && !sym_is_dc && sym_run == 4'd15 && sym_size == 4'd0) begin
          reset_n = 1'b0; #1;
          chk({tag, "_rst_busy"}, busy, 0);
          chk({tag, "_rst_valid"}, sym_valid, 0);
          chk({tag, "_rst_done"}, done, 0);
          @(negedge clock); reset_n = 1'b1; sym_ready = 1'b0; model_pred = 0;
          return;
        end
        start = 1'b0;
        if (mode != 0 && wait_n < 5) begin
          sym_ready = 1'b0;
          chk({tag, "_rd_stall"}, coef_rd_en, 0);
          wait_n++;
        end else begin
          sym_ready = (mode != 0) ? 1'b1 : ($urandom % 4 != 0);
          if (sym_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            wait_n = 0; last_hs = cyc;
          end
        end
      end else if (mode == 0) begin
        start = ($urandom % 3 == 0); clear_pred = $urandom % 2;
      end
      if (!fin) begin @(negedge clock); cyc++; end
    end
    start = 1'b0; clear_pred = 1'b0;
    if (!fin) begin
      chk({tag, "_timeout"}, 0, 1);
      do_reset();
      return;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_nexp_nonzero"}, (n_exp > 0), 1);
    @(negedge clock);
    chk({tag, "_done_pulse"}, {done, busy, sym_valid}, 3'b000);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 64; k++) coef_mem[k] = 0;
  endtask

  task automatic load_case3();
    clear_mem();
    coef_mem[1] = -1; coef_mem[20] = 6;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_mem();
    repeat (3) @(negedge clock);
    chk("rst_ctrl", {busy, done, coef_rd_en, sym_valid}, 4'b0000);
    chk("rst_addr", coef_addr, 0);
    chk("rst_sym", {sym_is_dc, sym_run, sym_size, sym_value}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_ctrl", {busy, done, sym_valid}, 3'b000);

    clear_mem(); coef_mem[0] = 5;  run_block("c1", 1'b1, 0);
    clear_mem(); coef_mem[0] = 3;  run_block("c2", 1'b0, 0);
    load_case3();                  run_block("c3", 1'b0, 0);
    clear_mem(); coef_mem[63] = 1023; run_block("c4", 1'b1, 0);
    load_case3();                  run_block("c5", 1'b0, 1);
    load_case3();                  run_block("c6a", 1'b0, 2);
    clear_mem(); coef_mem[0] = 4;  run_block("c6b", 1'b0, 0);

    for (int b = 0; b < 12; b++) begin
      int dens;
      clear_mem();
      coef_mem[0] = int'($urandom_range(0, 4094)) - 2047;
      dens = $urandom_range(1, 24);
      for (int k = 1; k < 64; k++)
        if ($urandom % dens == 0) begin
          coef_mem[k] = int'($urandom_range(0, 2046)) - 1023;
          if (coef_mem[k] == 0) coef_mem[k] = 1;
        end
      run_block("rnd", ($urandom % 2 == 1), b % 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
